// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_arb_pkg
// Brief   : Shared types and sizing helpers for the LPDDR2 port arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int unsigned TIMEOUT_DEF = 1023;

  // Counter width able to hold values up to and including the timeout.
  function automatic int unsigned to_width(input int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int unsigned TO_W = to_width(TIMEOUT_DEF);

endpackage

`default_nettype wire

// File: rtl/rr2_arbiter.sv
//------------------------------------------------------------------------------
// Module  : rr2_arbiter
// Brief   : Combinational 2-way alternating-priority picker, one-hot grant.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr2_arbiter
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,   // bit 0 = fetch, bit 1 = data
  input  owner_t     last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a tie the requester that did not own the port last time wins.
      2'b11:   gnt = (last == OWN_D) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lpddr2_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : lpddr2_port_arbiter
// Brief   : Shares one LPDDR2 word port between fetch and load/store requesters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lpddr2_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [29:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [29:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] lpddr2_address,
  output logic [31:0]       lpddr2_write_data,
  input  logic [31:0]       lpddr2_read_data,
  output logic              lpddr2_rreq,
  output logic              lpddr2_wreq,
  input  logic              lpddr2_ack,
  output logic              busy
);

  localparam int unsigned c_to_w =
    (TIMEOUT == TIMEOUT_DEF) ? TO_W : to_width(TIMEOUT);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  owner_t              r_last;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [c_to_w-1:0]   r_cnt;

  logic [1:0]          w_pick;
  logic [1:0]          w_gnt;
  logic                w_any_gnt;
  logic [29:0]         w_sel_addr;
  logic                w_oor;
  logic                w_timeout;

  rr2_arbiter u_rr2 (
    .req  ({d_req, if_req}),
    .last (r_last),
    .gnt  (w_pick)
  );

  // Grants only exist in IDLE and never while reset is being applied.
  assign w_gnt      = (r_state == ST_IDLE && !rst) ? w_pick : 2'b00;
  assign w_any_gnt  = |w_gnt;
  assign w_sel_addr = w_gnt[1] ? d_addr : if_addr;
  assign w_timeout  = (r_cnt == c_to_last);

  generate
    if (ADDR_W < 30) begin : g_oor
      assign w_oor = |w_sel_addr[29:ADDR_W];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_gnt) w_state_nxt = w_oor ? ST_RESP : ST_WAIT;
      ST_WAIT: if (lpddr2_ack || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_IF;
      r_last  <= OWN_D;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_gnt) begin
            r_owner <= w_gnt[1] ? OWN_D : OWN_IF;
            r_we    <= w_gnt[1] & d_we;
            r_addr  <= w_sel_addr[ADDR_W-1:0];
            r_wdata <= w_gnt[1] ? d_wdata : 32'h0;
            r_rdata <= 32'h0;
            r_err   <= w_oor;
            r_cnt   <= '0;
          end
        end
        ST_WAIT: begin
          // An ack arriving on the final allowed cycle still counts.
          if (lpddr2_ack) begin
            if (!r_we) r_rdata <= lpddr2_read_data;
            r_err <= 1'b0;
            r_cnt <= '0;
          end else if (w_timeout) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: r_last <= r_owner;
        default: r_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    if_gnt            = w_gnt[0];
    d_gnt             = w_gnt[1];
    if_rvalid         = 1'b0;
    if_rdata          = 32'h0;
    if_err            = 1'b0;
    d_rvalid          = 1'b0;
    d_rdata           = 32'h0;
    d_err             = 1'b0;
    lpddr2_address    = r_addr;
    lpddr2_write_data = r_wdata;
    lpddr2_rreq       = (r_state == ST_WAIT) & ~r_we;
    lpddr2_wreq       = (r_state == ST_WAIT) &  r_we;
    busy              = (r_state != ST_IDLE);
    if (r_state == ST_RESP) begin
      if (r_owner == OWN_IF) begin
        if_rvalid = 1'b1;
        if_rdata  = r_rdata;
        if_err    = r_err;
      end else begin
        d_rvalid  = 1'b1;
        d_rdata   = r_rdata;
        d_err     = r_err;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lpddr2_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_lpddr2_port_arbiter
// Brief   : Directed vector bench for lpddr2_port_arbiter (TIMEOUT = 8).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lpddr2_port_arbiter;

  localparam int ADDR_W  = 27;
  localparam int TIMEOUT = 8;
  localparam int NV      = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [29:0]       if_addr;
  logic              if_gnt, if_rvalid, if_err;
  logic [31:0]       if_rdata;
  logic              d_req, d_we;
  logic [29:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt, d_rvalid, d_err;
  logic [31:0]       d_rdata;
  logic [ADDR_W-1:0] lpddr2_address;
  logic [31:0]       lpddr2_write_data;
  logic [31:0]       lpddr2_read_data;
  logic              lpddr2_rreq, lpddr2_wreq, lpddr2_ack;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lpddr2_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .lpddr2_address(lpddr2_address), .lpddr2_write_data(lpddr2_write_data),
    .lpddr2_read_data(lpddr2_read_data), .lpddr2_rreq(lpddr2_rreq),
    .lpddr2_wreq(lpddr2_wreq), .lpddr2_ack(lpddr2_ack), .busy(busy)
  );

  typedef struct {
    logic        ifr;  logic [29:0] ifa;
    logic        dr;   logic        dwe;  logic [29:0] da;  logic [31:0] dwd;
    logic        ack;  logic [31:0] rd;
    logic        ig;   logic        irv;  logic [31:0] ird; logic        ierr;
    logic        dg;   logic        drv;  logic [31:0] drd; logic        derr;
    logic        rr;   logic        wr;   logic [26:0] addr; logic [31:0] wd;
    logic        busy;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    lpddr2_ack = 1'b0; lpddr2_read_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, " if_rvalid"}, {31'h0, if_rvalid}, 32'h0);
    chk({nm, " d_rvalid"},  {31'h0, d_rvalid},  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    //          ifr   ifa        dr    dwe   da              dwd            ack   rd
    //          ig    irv   ird            ierr  dg    drv   drd            derr
    //          rr    wr    addr          wd             busy
    vecs[0]  = '{1'b1, 30'h10, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b0, 27'h0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 27'h10, 32'h0, 1'b1};
    vecs[2]  = vecs[1];
    vecs[3]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b1, 32'h8C220004,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 27'h10, 32'h0, 1'b1};
    vecs[4]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b1, 32'h8C220004, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b0, 27'h0, 32'h0, 1'b1};
    vecs[5]  = '{1'b0, 30'h0, 1'b1, 1'b1, 30'h40, 32'hDEADBEEF, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b0, 27'h0, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b1, 27'h40, 32'hDEADBEEF, 1'b1};
    vecs[7]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b1, 32'h12345678,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b1, 27'h40, 32'hDEADBEEF, 1'b1};
    vecs[8]  = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0,
                 1'b0, 1'b0, 27'h0, 32'h0, 1'b1};
    // Bit 27 set: granted, no strobe, error response next cycle.
    vecs[9]  = '{1'b0, 30'h0, 1'b1, 1'b0, 30'h0800_0000, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b0, 27'h0, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1,
                 1'b0, 1'b0, 27'h0, 32'h0, 1'b1};
    vecs[11] = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b1, 32'h55AA55AA,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b0, 27'h0, 32'h0, 1'b0};
    vecs[12] = '{1'b0, 30'h0, 1'b1, 1'b0, 30'h55, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b0, 27'h0, 32'h0, 1'b0};
    // Fetch request raised while busy, then dropped before it could win.
    vecs[13] = '{1'b1, 30'h20, 1'b0, 1'b0, 30'h0, 32'h0, 1'b1, 32'hCAFEF00D,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 27'h55, 32'h0, 1'b1};
    vecs[14] = '{1'b1, 30'h20, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0,
                 1'b0, 1'b0, 27'h0, 32'h0, 1'b1};
    vecs[15] = '{1'b0, 30'h0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b0, 27'h0, 32'h0, 1'b0};

    // Reset state
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    #3;
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst strobes", {30'h0, lpddr2_rreq, lpddr2_wreq}, 32'h0);
    chk("rst rvalid", {30'h0, if_rvalid, d_rvalid}, 32'h0);
    chk("rst address", {5'h0, lpddr2_address}, 32'h0);
    chk("rst wdata", lpddr2_write_data, 32'h0);
    chk("rst rdata", if_rdata | d_rdata, 32'h0);
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
      d_req = vecs[i].dr; d_we = vecs[i].dwe; d_addr = vecs[i].da; d_wdata = vecs[i].dwd;
      lpddr2_ack = vecs[i].ack; lpddr2_read_data = vecs[i].rd;
      #3;
      chk($sformatf("v%0d if_gnt", i), {31'h0, if_gnt}, {31'h0, vecs[i].ig});
      chk($sformatf("v%0d if_rvalid", i), {31'h0, if_rvalid}, {31'h0, vecs[i].irv});
      chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].ird);
      chk($sformatf("v%0d if_err", i), {31'h0, if_err}, {31'h0, vecs[i].ierr});
      chk($sformatf("v%0d d_gnt", i), {31'h0, d_gnt}, {31'h0, vecs[i].dg});
      chk($sformatf("v%0d d_rvalid", i), {31'h0, d_rvalid}, {31'h0, vecs[i].drv});
      chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].drd);
      chk($sformatf("v%0d d_err", i), {31'h0, d_err}, {31'h0, vecs[i].derr});
      chk($sformatf("v%0d rreq", i), {31'h0, lpddr2_rreq}, {31'h0, vecs[i].rr});
      chk($sformatf("v%0d wreq", i), {31'h0, lpddr2_wreq}, {31'h0, vecs[i].wr});
      chk($sformatf("v%0d busy", i), {31'h0, busy}, {31'h0, vecs[i].busy});
      if (vecs[i].rr || vecs[i].wr)
        chk($sformatf("v%0d address", i), {5'h0, lpddr2_address}, {5'h0, vecs[i].addr});
      if (vecs[i].wr)
        chk($sformatf("v%0d write_data", i), lpddr2_write_data, vecs[i].wd);
      next_cycle();
    end

    // Both requesters continuously active from reset: IF, D, IF, D.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      logic        exp_if;
      logic [31:0] data;
      exp_if = (t % 2 == 0);
      data   = 32'hA000_0000 + 32'(t);
      if_req = 1'b1; if_addr = 30'h100 + 30'(t);
      d_req = 1'b1; d_we = 1'b0; d_addr = 30'h200 + 30'(t);
      lpddr2_ack = 1'b0;
      #3;
      chk($sformatf("alt%0d if_gnt", t), {31'h0, if_gnt}, {31'h0, exp_if});
      chk($sformatf("alt%0d d_gnt", t), {31'h0, d_gnt}, {31'h0, ~exp_if});
      next_cycle();
      lpddr2_ack = 1'b1; lpddr2_read_data = data;
      #3;
      chk($sformatf("alt%0d rreq", t), {31'h0, lpddr2_rreq}, 32'h1);
      chk($sformatf("alt%0d address", t), {5'h0, lpddr2_address},
          exp_if ? 32'h100 + 32'(t) : 32'h200 + 32'(t));
      next_cycle();
      lpddr2_ack = 1'b0;
      #3;
      chk($sformatf("alt%0d if_rvalid", t), {31'h0, if_rvalid}, {31'h0, exp_if});
      chk($sformatf("alt%0d d_rvalid", t), {31'h0, d_rvalid}, {31'h0, ~exp_if});
      chk($sformatf("alt%0d if_rdata", t), if_rdata, exp_if ? data : 32'h0);
      chk($sformatf("alt%0d d_rdata", t), d_rdata, exp_if ? 32'h0 : data);
      chk($sformatf("alt%0d resp gnt", t), {30'h0, if_gnt, d_gnt}, 32'h0);
      next_cycle();
    end
    idle_inputs();

    // Timeout: 8 strobe cycles, error response, stray ack afterwards ignored.
    if_req = 1'b1; if_addr = 30'h33;
    #3;
    chk("to if_gnt", {31'h0, if_gnt}, 32'h1);
    next_cycle();
    if_req = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      #3;
      chk($sformatf("to rreq%0d", k), {31'h0, lpddr2_rreq}, 32'h1);
      chk_quiet($sformatf("to wait%0d", k));
      next_cycle();
    end
    #3;
    chk("to if_rvalid", {31'h0, if_rvalid}, 32'h1);
    chk("to if_err", {31'h0, if_err}, 32'h1);
    chk("to if_rdata", if_rdata, 32'h0);
    chk("to rreq dropped", {31'h0, lpddr2_rreq}, 32'h0);
    next_cycle();
    lpddr2_ack = 1'b1; lpddr2_read_data = 32'hBAD0BAD0;
    #3;
    chk_quiet("stray ack");
    chk("stray busy", {31'h0, busy}, 32'h0);
    next_cycle();
    lpddr2_ack = 1'b0;
    #3;
    chk_quiet("after stray");
    chk("after stray busy", {31'h0, busy}, 32'h0);
    next_cycle();

    // Ack on the last allowed cycle beats the timeout.
    if_req = 1'b1; if_addr = 30'h34;
    #3;
    chk("late if_gnt", {31'h0, if_gnt}, 32'h1);
    next_cycle();
    if_req = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      lpddr2_ack = (k == TIMEOUT - 1); lpddr2_read_data = 32'h0000_0077;
      #3;
      chk($sformatf("late rreq%0d", k), {31'h0, lpddr2_rreq}, 32'h1);
      next_cycle();
    end
    lpddr2_ack = 1'b0;
    #3;
    chk("late if_rvalid", {31'h0, if_rvalid}, 32'h1);
    chk("late if_err", {31'h0, if_err}, 32'h0);
    chk("late if_rdata", if_rdata, 32'h0000_0077);
    next_cycle();

    // Reset during the second WAIT cycle aborts without a response.
    if_req = 1'b1; if_addr = 30'h44;
    #3;
    chk("abort if_gnt", {31'h0, if_gnt}, 32'h1);
    next_cycle();
    if_req = 1'b0;
    #3;
    chk("abort wait1 rreq", {31'h0, lpddr2_rreq}, 32'h1);
    next_cycle();
    rst = 1'b1;
    #3;
    chk("abort wait2 rreq", {31'h0, lpddr2_rreq}, 32'h1);
    next_cycle();
    rst = 1'b0;
    #3;
    chk("abort rreq", {31'h0, lpddr2_rreq}, 32'h0);
    chk("abort busy", {31'h0, busy}, 32'h0);
    chk_quiet("abort");
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      #3;
      chk_quiet($sformatf("abort idle%0d", k));
      next_cycle();
    end
    if_req = 1'b1; if_addr = 30'h45;
    #3;
    chk("post if_gnt", {31'h0, if_gnt}, 32'h1);
    next_cycle();
    if_req = 1'b0; lpddr2_ack = 1'b1; lpddr2_read_data = 32'h0000_0099;
    #3;
    chk("post address", {5'h0, lpddr2_address}, 32'h45);
    next_cycle();
    lpddr2_ack = 1'b0;
    #3;
    chk("post if_rvalid", {31'h0, if_rvalid}, 32'h1);
    chk("post if_rdata", if_rdata, 32'h0000_0099);
    chk("post if_err", {31'h0, if_err}, 32'h0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
